qc_var_circular_shifter: RTL and testbench

Pipelined circular shifter for the QC-LDPC datapath: rotates the low `z_val` bits of a MAXZ-wide word by a runtime shift, left or right, with `z_val` selectable per transaction (lifting size below MAXZ). It is the parametrised successor of the fixed-Z pipelined shifters: variable lifting size, runtime direction, a configurable number of log-shift stages per register, valid/ready flow control, and range-error flagging. It sits between the message memory and the check-node units.

---
 rtl/qc_var_circular_shifter.sv | 131 +++++++++++++
 tb/tb_qc_var_circular_shifter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qc_var_circular_shifter.sv
// Pipelined variable-Z circular shifter for the QC-LDPC datapath: rotates the low
// z_val bits of a MAXZ-wide word left or right, with global-stall valid/ready flow.
module qc_var_circular_shifter #(
  parameter int MAXZ             = 384,
  parameter int STAGES_PER_CYCLE = 2
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAXZ-1:0]            in_data,
  input  logic [$clog2(MAXZ)-1:0]    shift_val,
  input  logic [$clog2(MAXZ+1)-1:0]  z_val,
  input  logic                       dir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAXZ-1:0]            out_data,
  output logic                       out_err
);

  localparam int SW   = $clog2(MAXZ);
  localparam int NREG = (SW + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
  localparam int ZW   = $clog2(MAXZ + 1);
  localparam int DW   = 2 * MAXZ;
  localparam logic [ZW-1:0] MAXZ_Z = ZW'(MAXZ);

  function automatic logic [MAXZ-1:0] low_mask(input logic [ZW-1:0] z);
    low_mask = ~({MAXZ{1'b1}} << z);
  endfunction

  logic            en_s;
  logic [MAXZ-1:0] x_s;
  logic [ZW-1:0]   diff_s;
  logic [SW-1:0]   s_in_s;
  logic [DW-1:0]   d_in_s;
  logic            err_in_s;

  logic            vld_r [NREG+1];
  logic [DW-1:0]   d_r   [NREG+1];
  logic [SW-1:0]   s_r   [NREG+1];
  logic [ZW-1:0]   z_r   [NREG+1];
  logic            err_r [NREG+1];

  logic            out_valid_r;
  logic [MAXZ-1:0] out_data_r;
  logic            out_err_r;

  assign en_s      = !out_valid_r || out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;

  // Input stage: mask, convert a left rotate into the equivalent right rotate, double the word
  always_comb begin
    x_s    = in_data & low_mask(z_val);
    diff_s = z_val - ZW'(shift_val);
    if (!dir) begin
      s_in_s = shift_val;
    end else if (shift_val == {SW{1'b0}}) begin
      s_in_s = {SW{1'b0}};
    end else begin
      s_in_s = diff_s[SW-1:0];
    end
    d_in_s   = {{MAXZ{1'b0}}, x_s} | ({{MAXZ{1'b0}}, x_s} << z_val);
    err_in_s = (z_val == {ZW{1'b0}}) || (z_val > MAXZ_Z) || (ZW'(shift_val) >= z_val);
  end

  // Input stage register
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      vld_r[0] <= 1'b0;
      d_r[0]   <= {DW{1'b0}};
      s_r[0]   <= {SW{1'b0}};
      z_r[0]   <= {ZW{1'b0}};
      err_r[0] <= 1'b0;
    end else if (en_s) begin
      vld_r[0] <= in_valid;
      d_r[0]   <= d_in_s;
      s_r[0]   <= s_in_s;
      z_r[0]   <= z_val;
      err_r[0] <= err_in_s;
    end
  end

  for (genvar g = 1; g <= NREG; g++) begin : g_stage
    logic [DW-1:0] chain_s [STAGES_PER_CYCLE+1];
    assign chain_s[0] = d_r[g-1];

    // Each step k shifts by 2^k; steps past SW-1 in a partial last group pass through
    for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_step
      localparam int K = (g - 1) * STAGES_PER_CYCLE + j;
      if (K < SW) begin : g_act
        assign chain_s[j+1] = s_r[g-1][K] ? (chain_s[j] >> (1 << K)) : chain_s[j];
      end else begin : g_pass
        assign chain_s[j+1] = chain_s[j];
      end
    end

    // Shift group register
    always_ff @(posedge CLK) begin
      if (!rst_n) begin
        vld_r[g] <= 1'b0;
        d_r[g]   <= {DW{1'b0}};
        s_r[g]   <= {SW{1'b0}};
        z_r[g]   <= {ZW{1'b0}};
        err_r[g] <= 1'b0;
      end else if (en_s) begin
        vld_r[g] <= vld_r[g-1];
        d_r[g]   <= chain_s[STAGES_PER_CYCLE];
        s_r[g]   <= s_r[g-1];
        z_r[g]   <= z_r[g-1];
        err_r[g] <= err_r[g-1];
      end
    end
  end

  // Output register: final mask, error transactions forced to zero data
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {MAXZ{1'b0}};
      out_err_r   <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= vld_r[NREG];
      out_data_r  <= err_r[NREG] ? {MAXZ{1'b0}} : (d_r[NREG][MAXZ-1:0] & low_mask(z_r[NREG]));
      out_err_r   <= err_r[NREG];
    end
  end

endmodule

// File: tb/tb_qc_var_circular_shifter.sv
// Scoreboard bench for qc_var_circular_shifter with MAXZ=8, STAGES_PER_CYCLE=2.
module tb_qc_var_circular_shifter;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] shift_val;
  logic [3:0] z_val;
  logic       dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  int pop_cyc[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  qc_var_circular_shifter #(.MAXZ(8), .STAGES_PER_CYCLE(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift_val(shift_val), .z_val(z_val), .dir(dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: rotate right by s within z bits, out[i] = x[(i+s) mod z]; {err, data}
  function automatic logic [8:0] model(input logic [7:0] d, input int sh, input int z, input logic dr);
    logic [7:0] r;
    int s;
    r = 8'h00;
    if (z == 0 || z > 8 || sh >= z) return {1'b1, 8'h00};
    s = dr ? (z - sh) % z : sh;
    for (int i = 0; i < z; i++) r[i] = d[(i + s) % z];
    return {1'b0, r};
  endfunction

  task automatic send(input logic [7:0] d, input int sh, input int z, input logic dr,
                      input logic [8:0] e, input bit push);
    int g;
    in_data = d; shift_val = 3'(sh); z_val = 4'(z); dir = dr; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge CLK); #1; g++;
    end
    if (g >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
    if (push) exp_q.push_back(e);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge CLK); #1; g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop and compare whenever an output is handed over
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge CLK);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {23'd0, out_err, out_data}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard", {23'd0, out_err, out_data}, {23'd0, e});
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int z, sh;
    logic [7:0] pats [3];
    pats[0] = 8'hB5; pats[1] = 8'h0F; pats[2] = 8'hA5;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; shift_val = 3'd0;
    z_val = 4'd0; dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge CLK); #1;

    // Full-width rotate with latency measurement
    send(8'hB5, 3, 8, 1'b0, 9'h0B6, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(posedge CLK); #1; cnt++;
    end
    chk("latency", 32'(cnt), 32'd3);
    wait_drain();

    // Sweep all shifts, both directions, three patterns
    for (int p = 0; p < 3; p++)
      for (int dr = 0; dr < 2; dr++)
        for (int s = 0; s < 8; s++)
          send(pats[p], s, 8, dr[0], model(pats[p], s, 8, dr[0]), 1'b1);
    wait_drain();

    // Variable Z and shift-zero / z=1 corners
    send(8'hF6, 2, 5, 1'b0, 9'h015, 1'b1);
    send(8'hF6, 2, 5, 1'b1, 9'h01A, 1'b1);
    send(8'hAB, 0, 1, 1'b1, 9'h001, 1'b1);
    send(8'hAA, 0, 1, 1'b0, 9'h000, 1'b1);
    send(8'hB5, 0, 8, 1'b1, 9'h0B5, 1'b1);
    send(8'hFF, 0, 3, 1'b0, 9'h007, 1'b1);
    wait_drain();

    // Back-to-back streaming
    pop_cyc.delete();
    for (int t = 0; t < 16; t++) begin
      logic [7:0] d;
      logic dr;
      z  = int'($urandom_range(8, 1));
      sh = int'($urandom_range(32'(z - 1), 0));
      d  = 8'($urandom());
      dr = 1'($urandom());
      send(d, sh, z, dr, model(d, sh, z, dr), 1'b1);
    end
    wait_drain();
    chk("stream_count", 32'(pop_cyc.size()), 32'd16);
    if (pop_cyc.size() > 0)
      chk("stream_consecutive", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[0]), 32'd15);

    // Backpressure: fill the pipe, hold, then release
    out_ready = 1'b0;
    send(8'hB5, 3, 8, 1'b0, 9'h0B6, 1'b1);
    send(8'h0F, 1, 8, 1'b1, model(8'h0F, 1, 8, 1'b1), 1'b1);
    send(8'hA5, 4, 8, 1'b0, model(8'hA5, 4, 8, 1'b0), 1'b1);
    send(8'hF6, 2, 5, 1'b0, 9'h015, 1'b1);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < 3; h++) begin
      @(posedge CLK); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'hB6);
    end
    chk("bp_no_pop", 32'(exp_q.size()), 32'd4);
    out_ready = 1'b1;
    wait_drain();
    cnt = 0;
    for (int h = 0; h < 5; h++) begin
      @(posedge CLK); #1;
      if (out_valid) cnt++;
    end
    chk("bp_no_duplicate", 32'(cnt), 32'd0);

    // Error flagging, then a legal transaction right behind
    send(8'hF6, 5, 5, 1'b0, 9'h100, 1'b1);
    send(8'hFF, 0, 0, 1'b1, 9'h100, 1'b1);
    send(8'hFF, 3, 9, 1'b0, 9'h100, 1'b1);
    send(8'hF6, 2, 5, 1'b0, 9'h015, 1'b1);
    wait_drain();

    // Reset mid-flight: in-flight and during-reset inputs are discarded
    send(8'h5A, 1, 8, 1'b0, 9'h000, 1'b0);
    send(8'h3C, 2, 8, 1'b1, 9'h000, 1'b0);
    in_data = 8'hFF; shift_val = 3'd1; z_val = 4'd8; dir = 1'b0; in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int h = 0; h < 8; h++) begin
      @(posedge CLK); #1;
      if (out_valid) cnt++;
    end
    chk("rst_mid_no_output", 32'(cnt), 32'd0);
    send(8'hB5, 3, 8, 1'b0, 9'h0B6, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
